mem_stage_access: RTL and testbench
===================================

MEM_STAGE_ACCESS -- requirements
Module: mem_stage_access

Interface
REQ-001 Parameter: ADDR_W, default 32, data-memory byte-address width (>= 3).
REQ-002 clock  in  1  sole clock; all state updates on the rising edge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 ex_valid  in  1  EX/MEM instruction present.
REQ-005 ex_mem_read, ex_mem_write  in  1 each  load / store; both high is treated as a load.
REQ-006 ex_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 ex_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-008 alu_result  in  32  effective address (low ADDR_W bits) or non-memory result.
REQ-009 store_data  in  32  store operand.
REQ-010 dmem_req, dmem_we  out  1 each  memory request / write enable.
REQ-011 dmem_addr  out  ADDR_W  word-aligned address.
REQ-012 dmem_be  out  4  byte enables; dmem_wdata  out  32  write data.
REQ-013 dmem_ack  in  1  request completes in the cycle it is sampled high; dmem_rdata  in  32  valid with ack.
REQ-014 stall  out  1  upstream holds ex_* inputs while high.
REQ-015 data_from_mem_mux  out  32  result to the MEM/WB register; mem_out_valid  out  1  one-cycle result strobe.
REQ-016 misalign  out  1  misalignment trap strobe (see Configuration).

Function
REQ-017 Two states: IDLE and ACCESS.
REQ-018 stall SHALL equal (state==ACCESS), including the ack cycle.
REQ-019 IDLE, ex_valid, no memory op: next edge sets data_from_mem_mux=alu_result and mem_out_valid=1; throughput is one per cycle.
REQ-020 IDLE, ex_valid, load or store: next edge latches address, size, unsigned, we, wdata and be, and enters ACCESS.
REQ-021 In ACCESS, dmem_req SHALL be 1, with addr, we, be and wdata registered and stable until ack.
REQ-022 In ACCESS with dmem_ack=0: no change.
REQ-023 In ACCESS with dmem_ack=1, at the edge:
- return to IDLE and drop dmem_req;
- set mem_out_valid=1;
- load: data_from_mem_mux = aligned, extended dmem_rdata;
- store: data_from_mem_mux = latched address zero-extended.
REQ-024 Inputs in ACCESS SHALL be ignored; the held instruction is accepted in the first IDLE cycle.
REQ-025 Latency: non-memory result 1 edge after acceptance; memory result 2 + wait-cycles edges after acceptance.
REQ-026 Little-endian byte lane = addr[1:0].
- Store byte: be = 0001<<lane, wdata = byte replicated x4.
- Store half: be = 0011<<{addr[1],0}, wdata = half replicated x2.
- Store word: be = 1111.
- Loads: dmem_we=0, be=1111.
REQ-027 Load extraction SHALL select the byte or half from rdata by lane, then sign- or zero-extend to 32 bits.
REQ-028 mem_out_valid is 0 in every cycle not named in REQ-019 or REQ-023; data_from_mem_mux holds otherwise.
REQ-029 dmem_ack while in IDLE SHALL be ignored.

Reset
REQ-030 resetn=0 at an edge: state=IDLE and all outputs 0, including mid-access; the access is abandoned and no result is produced.
REQ-031 resetn=0 SHALL take priority over ack and acceptance in the same cycle.

Configuration
REQ-032 With MEM_STAGE_MISALIGN_TRAP_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is accepted in IDLE.
- No request is issued and the state stays IDLE.
- misalign=1 for one cycle; mem_out_valid=0; data_from_mem_mux holds.
REQ-033 Without the macro: misalign tied 0; a misaligned half uses lane {addr[1],0]; a misaligned word uses lane 0.

Verification
REQ-034 Non-memory op alu_result=0x1234_5678 in IDLE -> next cycle data_from_mem_mux=0x1234_5678, mem_out_valid=1, stall=0.
REQ-035 Load byte signed, addr 0x103, rdata 0x80FF_0000, ack after 2 wait cycles -> dmem_addr=0x100, stall high 3 cycles, result 0xFFFF_FF80.
REQ-036 Store half, addr 0x22, store_data 0x0000_ABCD, zero-wait ack -> dmem_we=1, be=1100, wdata=0xABCD_ABCD, one-cycle mem_out_valid.
REQ-037 resetn=0 during ACCESS before ack, then a late ack -> dmem_req=0 next edge, mem_out_valid never asserted.
REQ-038 Word load at addr 0x6 -> with macro: misalign=1, no dmem_req; without macro: dmem_addr=0x4, full-word result.
REQ-039 Back-to-back load then non-memory op held during stall -> non-memory result exactly 1 edge after the load's mem_out_valid.

Source files
------------

// File: rtl/mem_stage_access.sv
// MEM-stage data-memory access: IDLE/ACCESS handshake with the data memory, store lane steering, load extraction.
// Optional define MEM_STAGE_MISALIGN_TRAP_EN turns misaligned half/word accesses into a one-cycle misalign strobe.
module mem_stage_access #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       store_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              stall,
  output logic [31:0]       data_from_mem_mux,
  output logic              mem_out_valid,
  output logic              misalign,
  output logic              state_dbg
);

  // Memory handshake: dmem_req stays high with stable addr/we/be/wdata
  // until dmem_ack is sampled high; the access completes on that edge.
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       data_q;
  logic              valid_q;
  logic              misalign_q;

  logic              is_mem;
  logic              misaligned_in;
  logic              accept_nonmem;
  logic              accept_mem;
  logic              trap;
  logic              complete;
  logic [1:0]        lane_in;
  logic [3:0]        be_in;
  logic [31:0]       wdata_in;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       load_val;
  logic [31:0]       addr_ext;

  assign is_mem  = ex_mem_read | ex_mem_write;
  assign lane_in = alu_result[1:0];

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign misaligned_in = ((ex_size == 2'b01) && lane_in[0]) ||
                         (ex_size[1] && (lane_in != 2'b00));
`else
  assign misaligned_in = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    accept_nonmem = 1'b0;
    accept_mem    = 1'b0;
    trap          = 1'b0;
    complete      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            accept_nonmem = 1'b1;
          end else if (misaligned_in) begin
            trap = 1'b1;
          end else begin
            accept_mem = 1'b1;
            state_d    = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Store lane steering; a misaligned half falls back to lane {addr[1],0}, a word to lane 0.
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = store_data;
    if (!ex_mem_read) begin
      case (ex_size)
        2'b00: begin
          be_in    = 4'b0001 << lane_in;
          wdata_in = {4{store_data[7:0]}};
        end
        2'b01: begin
          be_in    = 4'b0011 << {lane_in[1], 1'b0};
          wdata_in = {2{store_data[15:0]}};
        end
        default: begin
          be_in    = 4'b1111;
          wdata_in = store_data;
        end
      endcase
    end
  end

  always_comb begin
    load_byte = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
    load_half = dmem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_val = unsigned_q ? {24'h0, load_byte} : {{24{load_byte[7]}}, load_byte};
      2'b01:   load_val = unsigned_q ? {16'h0, load_half} : {{16{load_half[15]}}, load_half};
      default: load_val = dmem_rdata;
    endcase
  end

  always_comb begin
    addr_ext             = '0;
    addr_ext[ADDR_W-1:0] = addr_q;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h0;
      data_q     <= 32'h0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= accept_nonmem | complete;
      misalign_q <= trap;
      if (accept_nonmem) data_q <= alu_result;
      if (accept_mem) begin
        addr_q     <= alu_result[ADDR_W-1:0];
        size_q     <= ex_size;
        unsigned_q <= ex_unsigned;
        we_q       <= ~ex_mem_read;
        be_q       <= be_in;
        wdata_q    <= wdata_in;
      end
      if (complete) data_q <= we_q ? addr_ext : load_val;
    end
  end

  assign dmem_req          = (state_q == ACCESS);
  assign stall             = (state_q == ACCESS);
  assign dmem_we           = we_q;
  assign dmem_addr         = {addr_q[ADDR_W-1:2], 2'b00};
  assign dmem_be           = be_q;
  assign dmem_wdata        = wdata_q;
  assign data_from_mem_mux = data_q;
  assign mem_out_valid     = valid_q;
  assign misalign          = misalign_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: reset, ALU pass-through, loads/stores, waits, reset mid-access, misalignment.
module tb_mem_stage_access;

  logic        clock = 1'b0;
  logic        resetn;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_unsigned;
  logic [1:0]  ex_size;
  logic [31:0] alu_result, store_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        stall, mem_out_valid, misalign, state_dbg;
  logic [31:0] data_from_mem_mux;

  int checks = 0;
  int errors = 0;

  mem_stage_access #(.ADDR_W(32)) dut (
    .clock(clock), .resetn(resetn), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_size(ex_size), .ex_unsigned(ex_unsigned),
    .alu_result(alu_result), .store_data(store_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .data_from_mem_mux(data_from_mem_mux),
    .mem_out_valid(mem_out_valid), .misalign(misalign), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Load extraction table, rdata = F1E2_83C4 (lanes: C4 83 E2 F1)
  logic [1:0]  t_size [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00};
  logic        t_uns  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        t_wr   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] t_addr [7] = '{32'h200, 32'h201, 32'h202, 32'h200, 32'h202, 32'h204, 32'h203};
  logic [31:0] t_exp  [7] = '{32'hFFFF_FFC4, 32'h0000_0083, 32'hFFFF_FFE2, 32'hFFFF_83C4,
                              32'h0000_F1E2, 32'hF1E2_83C4, 32'hFFFF_FFF1};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_size = 2'b00; ex_unsigned = 0;
    alu_result = 0; store_data = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    tick(); tick();
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", dmem_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (mem_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", mem_out_valid); end
    checks++; if (data_from_mem_mux !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", data_from_mem_mux); end
    checks++; if ({dmem_we, dmem_be, dmem_addr, dmem_wdata} !== 69'h0) begin errors++; $display("FAIL reset_bus got we=%b be=%b addr=%h wd=%h exp 0", dmem_we, dmem_be, dmem_addr, dmem_wdata); end
    checks++; if ({misalign, state_dbg} !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", {misalign, state_dbg}); end
    resetn = 1;
    tick();
  endtask

  task automatic test_nonmem();
    ex_valid = 1; alu_result = 32'h1234_5678;
    tick();
    ex_valid = 0;
    checks++; if (data_from_mem_mux !== 32'h1234_5678) begin errors++; $display("FAIL nonmem_data got %h exp 12345678", data_from_mem_mux); end
    checks++; if (mem_out_valid !== 1'b1) begin errors++; $display("FAIL nonmem_valid got %b exp 1", mem_out_valid); end
    checks++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL nonmem_stall got stall=%b req=%b exp 0 0", stall, dmem_req); end
    tick();
    checks++; if (mem_out_valid !== 1'b0) begin errors++; $display("FAIL nonmem_strobe got %b exp 0", mem_out_valid); end
    checks++; if (data_from_mem_mux !== 32'h1234_5678) begin errors++; $display("FAIL nonmem_hold got %h exp 12345678", data_from_mem_mux); end
  endtask

  task automatic test_load_byte_wait();
    int stall_cycles = 0;
    ex_valid = 1; ex_mem_read = 1; ex_size = 2'b00; ex_unsigned = 0; alu_result = 32'h103;
    tick();
    idle_inputs();
    checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100) begin errors++; $display("FAIL ldb_req got req=%b addr=%h exp 1 00000100", dmem_req, dmem_addr); end
    checks++; if (dmem_we !== 1'b0 || dmem_be !== 4'b1111) begin errors++; $display("FAIL ldb_we_be got we=%b be=%b exp 0 1111", dmem_we, dmem_be); end
    if (stall) stall_cycles++;
    tick();
    if (stall) stall_cycles++;
    checks++; if (mem_out_valid !== 1'b0 || dmem_addr !== 32'h100) begin errors++; $display("FAIL ldb_wait got valid=%b addr=%h exp 0 00000100", mem_out_valid, dmem_addr); end
    tick();
    if (stall) stall_cycles++;
    dmem_ack = 1; dmem_rdata = 32'h80FF_0000;
    tick();
    if (stall) stall_cycles++;
    dmem_ack = 0; dmem_rdata = 0;
    checks++; if (stall_cycles !== 3) begin errors++; $display("FAIL ldb_stall_cycles got %0d exp 3", stall_cycles); end
    checks++; if (data_from_mem_mux !== 32'hFFFF_FF80 || mem_out_valid !== 1'b1) begin errors++; $display("FAIL ldb_result got %h v=%b exp ffffff80 1", data_from_mem_mux, mem_out_valid); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL ldb_req_drop got %b exp 0", dmem_req); end
    tick();
    checks++; if (mem_out_valid !== 1'b0) begin errors++; $display("FAIL ldb_strobe got %b exp 0", mem_out_valid); end
  endtask

  task automatic test_store_half();
    ex_valid = 1; ex_mem_write = 1; ex_size = 2'b01; alu_result = 32'h22; store_data = 32'h0000_ABCD;
    tick();
    idle_inputs();
    checks++; if (dmem_we !== 1'b1 || dmem_be !== 4'b1100) begin errors++; $display("FAIL sth_we_be got we=%b be=%b exp 1 1100", dmem_we, dmem_be); end
    checks++; if (dmem_wdata !== 32'hABCD_ABCD || dmem_addr !== 32'h20) begin errors++; $display("FAIL sth_bus got wd=%h addr=%h exp abcdabcd 00000020", dmem_wdata, dmem_addr); end
    dmem_ack = 1;
    tick();
    dmem_ack = 0;
    checks++; if (mem_out_valid !== 1'b1 || data_from_mem_mux !== 32'h22) begin errors++; $display("FAIL sth_result got v=%b d=%h exp 1 00000022", mem_out_valid, data_from_mem_mux); end
    checks++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL sth_idle got stall=%b req=%b exp 0 0", stall, dmem_req); end
    tick();
    checks++; if (mem_out_valid !== 1'b0) begin errors++; $display("FAIL sth_strobe got %b exp 0", mem_out_valid); end
  endtask

  task automatic test_stores();
    ex_valid = 1; ex_mem_write = 1; ex_size = 2'b00; alu_result = 32'h1; store_data = 32'h1234_56A5;
    tick();
    idle_inputs();
    checks++; if (dmem_be !== 4'b0010 || dmem_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL stb_bus got be=%b wd=%h exp 0010 a5a5a5a5", dmem_be, dmem_wdata); end
    dmem_ack = 1;
    tick();
    dmem_ack = 0;
    ex_valid = 1; ex_mem_write = 1; ex_size = 2'b10; alu_result = 32'h8; store_data = 32'h1122_3344;
    tick();
    idle_inputs();
    checks++; if (dmem_be !== 4'b1111 || dmem_wdata !== 32'h1122_3344 || dmem_addr !== 32'h8) begin errors++; $display("FAIL stw_bus got be=%b wd=%h addr=%h exp 1111 11223344 00000008", dmem_be, dmem_wdata, dmem_addr); end
    dmem_ack = 1;
    tick();
    dmem_ack = 0;
    checks++; if (data_from_mem_mux !== 32'h8 || mem_out_valid !== 1'b1) begin errors++; $display("FAIL stw_result got %h v=%b exp 00000008 1", data_from_mem_mux, mem_out_valid); end
    tick();
  endtask

  task automatic test_load_extract();
    for (int i = 0; i < 7; i++) begin
      ex_valid = 1; ex_mem_read = 1; ex_mem_write = t_wr[i]; ex_size = t_size[i];
      ex_unsigned = t_uns[i]; alu_result = t_addr[i];
      tick();
      idle_inputs();
      checks++; if (dmem_we !== 1'b0 || dmem_be !== 4'b1111) begin errors++; $display("FAIL ld_tab%0d_bus got we=%b be=%b exp 0 1111", i, dmem_we, dmem_be); end
      dmem_ack = 1; dmem_rdata = 32'hF1E2_83C4;
      tick();
      dmem_ack = 0; dmem_rdata = 0;
      checks++; if (data_from_mem_mux !== t_exp[i] || mem_out_valid !== 1'b1) begin errors++; $display("FAIL ld_tab%0d got %h v=%b exp %h 1", i, data_from_mem_mux, mem_out_valid, t_exp[i]); end
    end
    tick();
  endtask

  task automatic test_reset_mid_access();
    ex_valid = 1; ex_mem_read = 1; ex_size = 2'b10; alu_result = 32'h40;
    tick();
    idle_inputs();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req got %b exp 1", dmem_req); end
    resetn = 0;
    tick();
    resetn = 1; dmem_ack = 1; dmem_rdata = 32'h5555_5555;
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b0 || data_from_mem_mux !== 32'h0) begin errors++; $display("FAIL rst_mid_drop got req=%b stall=%b d=%h exp 0 0 0", dmem_req, stall, data_from_mem_mux); end
    tick();
    dmem_ack = 0;
    checks++; if (mem_out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_late_ack got %b exp 0", mem_out_valid); end
    // reset and ack in the same cycle
    ex_valid = 1; ex_mem_read = 1; ex_size = 2'b10; alu_result = 32'h44;
    tick();
    idle_inputs();
    resetn = 0; dmem_ack = 1; dmem_rdata = 32'h7777_7777;
    tick();
    resetn = 1; dmem_ack = 0;
    checks++; if (mem_out_valid !== 1'b0 || data_from_mem_mux !== 32'h0 || dmem_req !== 1'b0) begin errors++; $display("FAIL rst_prio got v=%b d=%h req=%b exp 0 0 0", mem_out_valid, data_from_mem_mux, dmem_req); end
    tick();
  endtask

  task automatic test_ack_idle();
    dmem_ack = 1; dmem_rdata = 32'h1111_1111;
    tick();
    tick();
    dmem_ack = 0;
    checks++; if (mem_out_valid !== 1'b0 || stall !== 1'b0 || state_dbg !== 1'b0) begin errors++; $display("FAIL ack_idle got v=%b stall=%b st=%b exp 0 0 0", mem_out_valid, stall, state_dbg); end
  endtask

  task automatic test_misalign();
    ex_valid = 1; alu_result = 32'hCAFE_0001;
    tick();
    ex_valid = 1; ex_mem_read = 1; ex_size = 2'b10; alu_result = 32'h6;
    tick();
    idle_inputs();
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    checks++; if (misalign !== 1'b1 || dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL mis_word got mis=%b req=%b stall=%b exp 1 0 0", misalign, dmem_req, stall); end
    checks++; if (mem_out_valid !== 1'b0 || data_from_mem_mux !== 32'hCAFE_0001) begin errors++; $display("FAIL mis_word_hold got v=%b d=%h exp 0 cafe0001", mem_out_valid, data_from_mem_mux); end
    ex_valid = 1; ex_mem_read = 1; ex_size = 2'b01; alu_result = 32'h201;
    tick();
    idle_inputs();
    checks++; if (misalign !== 1'b1 || dmem_req !== 1'b0) begin errors++; $display("FAIL mis_half got mis=%b req=%b exp 1 0", misalign, dmem_req); end
    tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_strobe got %b exp 0", misalign); end
`else
    checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h4 || misalign !== 1'b0) begin errors++; $display("FAIL mis_word got req=%b addr=%h mis=%b exp 1 00000004 0", dmem_req, dmem_addr, misalign); end
    dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_ack = 0;
    checks++; if (data_from_mem_mux !== 32'hDEAD_BEEF || mem_out_valid !== 1'b1) begin errors++; $display("FAIL mis_word_data got %h v=%b exp deadbeef 1", data_from_mem_mux, mem_out_valid); end
    ex_valid = 1; ex_mem_read = 1; ex_size = 2'b01; alu_result = 32'h201;
    tick();
    idle_inputs();
    dmem_ack = 1; dmem_rdata = 32'hF1E2_83C4;
    tick();
    dmem_ack = 0;
    checks++; if (data_from_mem_mux !== 32'hFFFF_83C4 || misalign !== 1'b0) begin errors++; $display("FAIL mis_half_data got %h mis=%b exp ffff83c4 0", data_from_mem_mux, misalign); end
    tick();
`endif
  endtask

  task automatic test_back_to_back();
    ex_valid = 1; ex_mem_read = 1; ex_size = 2'b01; ex_unsigned = 1; alu_result = 32'h12;
    tick();
    ex_mem_read = 0; ex_unsigned = 0; ex_size = 2'b00; alu_result = 32'h55AA_55AA;
    tick();
    checks++; if (stall !== 1'b1 || mem_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_hold got stall=%b v=%b exp 1 0", stall, mem_out_valid); end
    dmem_ack = 1; dmem_rdata = 32'h8001_7FFF;
    tick();
    dmem_ack = 0; dmem_rdata = 0;
    checks++; if (data_from_mem_mux !== 32'h0000_8001 || mem_out_valid !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL b2b_load got %h v=%b stall=%b exp 00008001 1 0", data_from_mem_mux, mem_out_valid, stall); end
    tick();
    ex_valid = 0;
    checks++; if (data_from_mem_mux !== 32'h55AA_55AA || mem_out_valid !== 1'b1) begin errors++; $display("FAIL b2b_alu got %h v=%b exp 55aa55aa 1", data_from_mem_mux, mem_out_valid); end
    tick();
    checks++; if (mem_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_strobe got %b exp 0", mem_out_valid); end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load_byte_wait();
    test_store_half();
    test_stores();
    test_load_extract();
    test_reset_mid_access();
    test_ack_idle();
    test_misalign();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
